mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences the MEM stage. Consumes the registered M-control, ALU result, zero flag and
//  store data held in the EX/MEM pipeline register, and runs a req/ack handshake to a
//  multi-cycle data memory. Stalls all pipeline registers until the access completes.
//  Resolves branches (pc_src/flush). Sits between the EX/MEM register and data memory.
// PARAMETERS
//  ADDR_W   32  memory address width (taken from alu_result[ADDR_W-1:0])
//  DATA_W   32  load/store data width
//  TIMEOUT  16  max cycles in ACCESS awaiting mem_ack before abort (>=2)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       synchronous active-low reset
//  m_ctl        in   3       EX/MEM M-control: [2]=branch [1]=memread [0]=memwrite
//  zero         in   1       EX/MEM ALU zero flag
//  alu_result   in   32      EX/MEM ALU result = memory byte address
//  wdata        in   DATA_W  EX/MEM read-data-2 (store data)
//  mem_req      out  1       memory request, held high until ack
//  mem_we       out  1       1 = write, 0 = read; valid while mem_req
//  mem_addr     out  ADDR_W  latched address; valid while mem_req
//  mem_wdata    out  DATA_W  latched store data; valid while mem_req
//  mem_ack      in   1       memory completion, 1-cycle pulse
//  mem_rdata    in   DATA_W  load data, valid with mem_ack
//  rdata        out  DATA_W  captured load data to MEM/WB, held until next load completes
//  stall        out  1       hold PC, IF/ID, ID/EX, EX/MEM (combinational)
//  pc_src       out  1       branch taken (combinational)
//  flush        out  1       squash IF/ID and ID/EX (== pc_src)
//  align_err    out  1       1-cycle pulse: misaligned access dropped
//  bus_err      out  1       1-cycle pulse: access timed out
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, cnt=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0,
//   rdata=0, align_err=0, bus_err=0. Combinational outputs follow from IDLE and live inputs.
//  acc = m_ctl[1] | m_ctl[0]. Write priority: both bits set -> treated as write.
//  mis = acc & (alu_result[1:0] != 0).
//  FSM: IDLE, ACCESS, DONE.
//   IDLE:   acc & !mis -> ACCESS. Latch mem_addr, mem_wdata, mem_we=m_ctl[0]; cnt<=0.
//           stall=1 this cycle (combinational). acc & mis -> stay IDLE, no request, stall=0,
//           align_err pulses next cycle.
//   ACCESS: mem_req=1, stall=1, cnt++ each cycle.
//           mem_ack -> DONE; if !mem_we, rdata<=mem_rdata.
//           no ack & cnt==TIMEOUT-1 -> DONE; bus_err pulses next cycle; rdata<=0 if read.
//           ack and timeout in same cycle -> ack wins, no bus_err.
//   DONE:   mem_req=0, stall=0 for exactly 1 cycle so the pipeline advances -> IDLE.
//           Prevents re-issue of the same EX/MEM contents.
//  Latency: an access whose ack comes k cycles after ACCESS entry (k>=1) stalls k+1 cycles.
//   Zero-wait ack is impossible (mem_req is registered).
//  Branch: pc_src = flush = m_ctl[2] & zero & (state==IDLE). Not gated by acc.
//  mem_ack outside ACCESS is ignored (late ack after reset/timeout): no state or rdata change.
//  Reset mid-ACCESS: mem_req drops at that edge; the transaction is abandoned.
//  mem_addr/mem_wdata/mem_we are stable for the whole ACCESS state.
//  cnt width: clog2(TIMEOUT); cnt never wraps (leaves ACCESS at TIMEOUT-1).
// TESTING
//  T1 load: m_ctl=3'b010, alu_result=0x40, ack 3 cycles after req with rdata=0xDEADBEEF
//     -> mem_req high 3 cycles, we=0, addr=0x40; stall high 4 cycles; rdata=0xDEADBEEF.
//  T2 store: m_ctl=3'b001, addr=0x80, wdata=0x12345678, ack after 1 cycle
//     -> we=1, wdata stable while req; stall 2 cycles; rdata unchanged.
//  T3 timeout: TIMEOUT=16, load, never ack -> req high 16 cycles; bus_err 1-cycle pulse;
//     rdata=0; DONE then IDLE; a later stray ack is ignored.
//  T4 misaligned: m_ctl=3'b010, addr=0x42 -> no mem_req; stall=0; align_err pulses once.
//  T5 branch: m_ctl=3'b100, zero=1 -> pc_src=flush=1 same cycle. zero=0 -> both 0.
//  T6 reset: rst_n=0 in the 2nd ACCESS cycle -> next edge req=0, stall=0, state IDLE;
//     ack on the following cycle is ignored; the next load completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: runs a req/ack handshake to a multi-cycle data memory,
// stalls the pipeline while an access is outstanding and resolves branches.
module mem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        m_ctl,
    input  logic              zero,
    input  logic [31:0]       alu_result,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              pc_src,
    output logic              flush,
    output logic              align_err,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              align_err_reg, align_err_next;
    logic              bus_err_reg, bus_err_next;

    logic acc;
    logic mis;

    assign acc = m_ctl[1] | m_ctl[0];
    assign mis = acc & (alu_result[1:0] != 2'b00);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        we_next        = we_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        rdata_next     = rdata_reg;
        align_err_next = 1'b0;
        bus_err_next   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (acc && !mis) begin
                    state_next = S_ACCESS;
                    cnt_next   = '0;
                    // Write wins when both memread and memwrite are set.
                    we_next    = m_ctl[0];
                    addr_next  = alu_result[ADDR_W-1:0];
                    wdata_next = wdata;
                end else if (acc && mis) begin
                    align_err_next = 1'b1;
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    state_next = S_DONE;
                    if (!we_reg) begin
                        rdata_next = mem_rdata;
                    end
                end else if (cnt_reg == CNT_LAST) begin
                    state_next   = S_DONE;
                    bus_err_next = 1'b1;
                    if (!we_reg) begin
                        rdata_next = '0;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            align_err_reg <= 1'b0;
            bus_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            rdata_reg     <= rdata_next;
            align_err_reg <= align_err_next;
            bus_err_reg   <= bus_err_next;
        end
    end

    // mem_req is a decode of registered state, so it can never see a same-cycle ack.
    assign mem_req   = (state_reg == S_ACCESS);
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign rdata     = rdata_reg;
    assign align_err = align_err_reg;
    assign bus_err   = bus_err_reg;

    always_comb begin
        stall = 1'b0;
        case (state_reg)
            S_IDLE:   stall = acc & ~mis;
            S_ACCESS: stall = 1'b1;
            default:  stall = 1'b0;
        endcase
    end

    assign pc_src = m_ctl[2] & zero & (state_reg == S_IDLE);
    assign flush  = pc_src;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a responder drives mem_ack after a chosen delay
// and a scoreboard queue holds the expected outcome of each access.
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  m_ctl;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] rdata;
    logic        stall;
    logic        pc_src;
    logic        flush;
    logic        align_err;
    logic        bus_err;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] rdata;
        int          nreq;
        int          nstall;
        logic        berr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rdata = '0;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_ctl      (m_ctl),
        .zero       (zero),
        .alu_result (alu_result),
        .wdata      (wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .rdata      (rdata),
        .stall      (stall),
        .pc_src     (pc_src),
        .flush      (flush),
        .align_err  (align_err),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ack_k = cycle of mem_req on which ack is returned; 0 means never.
    task automatic run_access(input string name, input logic [2:0] ctl, input logic [31:0] addr,
                              input logic [31:0] wd, input int ack_k, input logic [31:0] rd);
        exp_t e;
        exp_t got;
        int   n_req   = 0;
        int   n_stall = 0;
        bit   done    = 0;
        logic exp_we;
        exp_we = ctl[0];
        m_ctl = ctl;
        alu_result = addr;
        wdata = wd;
        #1;
        e.nreq   = (ack_k == 0) ? TIMEOUT : ack_k;
        e.nstall = e.nreq + 1;
        e.berr   = (ack_k == 0);
        if (!exp_we) model_rdata = (ack_k == 0) ? 32'h0 : rd;
        e.rdata  = model_rdata;
        sb.push_back(e);
        check({name, "_req_idle"}, {31'b0, mem_req}, 32'd0);
        if (stall) n_stall++;
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            mem_ack = 1'b0;
            if (stall) n_stall++;
            if (mem_req) begin
                n_req++;
                if (n_req == 1) begin
                    check({name, "_addr"}, mem_addr, addr);
                    check({name, "_we"}, {31'b0, mem_we}, {31'b0, exp_we});
                    check({name, "_pcsrc_busy"}, {31'b0, pc_src}, 32'd0);
                end
                if (exp_we && mem_wdata !== wd) check({name, "_wdata_stable"}, mem_wdata, wd);
                if (n_req == ack_k) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd;
                end
            end else begin
                done = 1;
                got = sb.pop_front();
                check({name, "_done_stall"}, {31'b0, stall}, 32'd0);
                check({name, "_bus_err"}, {31'b0, bus_err}, {31'b0, got.berr});
                check({name, "_rdata"}, rdata, got.rdata);
                check({name, "_nreq"}, n_req, got.nreq);
                check({name, "_nstall"}, n_stall, got.nstall);
                m_ctl = 3'b000;
            end
        end
        if (!done) check({name, "_finished_in_bound"}, 32'd0, 32'd1);
        tick();
        check({name, "_idle_after"}, {30'b0, mem_req, bus_err}, 32'd0);
        $display("txn %s ctl=%b addr=%h req_cycles=%0d stall_cycles=%0d rdata=%h",
                 name, ctl, addr, n_req, n_stall, rdata);
    endtask

    initial begin
        rst_n = 1'b0;
        m_ctl = 3'b000;
        zero = 1'b0;
        alu_result = '0;
        wdata = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        check("reset_outs", {26'b0, mem_req, mem_we, stall, pc_src, align_err, bus_err}, 32'd0);
        check("reset_addr", mem_addr, 32'd0);
        check("reset_wdata", mem_wdata, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // T1 load, T2 store
        run_access("t1_load", 3'b010, 32'h40, 32'h0, 3, 32'hDEADBEEF);
        run_access("t2_store", 3'b001, 32'h80, 32'h12345678, 1, 32'hAAAA5555);
        run_access("rw_both_write", 3'b011, 32'h84, 32'hCAFEF00D, 2, 32'h11111111);

        // T3 timeout, then a stray ack in IDLE must be ignored
        run_access("t3_timeout", 3'b010, 32'h100, 32'h0, 0, 32'h0);
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF0000;
        tick();
        mem_ack = 1'b0;
        check("t3_stray_ack_rdata", rdata, 32'h0);
        check("t3_stray_ack_req", {31'b0, mem_req}, 32'd0);
        $display("txn t3_stray_ack rdata=%h", rdata);

        // T4 misaligned load
        m_ctl = 3'b010;
        alu_result = 32'h42;
        #1;
        check("t4_stall", {31'b0, stall}, 32'd0);
        tick();
        m_ctl = 3'b000;
        check("t4_align_err", {31'b0, align_err}, 32'd1);
        check("t4_no_req", {31'b0, mem_req}, 32'd0);
        tick();
        check("t4_align_pulse_end", {31'b0, align_err}, 32'd0);
        $display("txn t4_misaligned addr=42");

        // T5 branch
        m_ctl = 3'b100;
        zero = 1'b1;
        #1;
        check("t5_taken", {30'b0, pc_src, flush}, 32'd3);
        zero = 1'b0;
        #1;
        check("t5_not_taken", {30'b0, pc_src, flush}, 32'd0);
        m_ctl = 3'b000;
        tick();
        $display("txn t5_branch");

        // T6 reset in the 2nd ACCESS cycle
        m_ctl = 3'b010;
        alu_result = 32'h200;
        tick();
        check("t6_access1_req", {31'b0, mem_req}, 32'd1);
        tick();
        check("t6_access2_req", {31'b0, mem_req}, 32'd1);
        rst_n = 1'b0;
        m_ctl = 3'b000;
        tick();
        rst_n = 1'b1;
        check("t6_reset_req", {31'b0, mem_req}, 32'd0);
        check("t6_reset_stall", {31'b0, stall}, 32'd0);
        mem_ack = 1'b1;
        mem_rdata = 32'h77777777;
        tick();
        mem_ack = 1'b0;
        check("t6_late_ack_rdata", rdata, 32'h0);
        check("t6_late_ack_req", {31'b0, mem_req}, 32'd0);
        $display("txn t6_reset_abandon rdata=%h", rdata);
        model_rdata = 32'h0;
        run_access("t6_next_load", 3'b010, 32'h204, 32'h0, 2, 32'h0BADC0DE);

        if (sb.size() != 0) check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
